// File: rtl/nl_outvc_alloc_ctrl_pkg.sv
// Shared router definitions: port/VC counts, port naming, per-VC state
// encoding and the turn-legality function used to mask requesters.
package nl_outvc_alloc_ctrl_pkg;

  localparam int NL_NP        = 5;
  localparam int NL_NV        = 4;
  localparam int NL_BUF_DEPTH = 4;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } output_port_t;

  typedef enum logic {
    VC_FREE  = 1'b0,
    VC_ALLOC = 1'b1
  } vc_state_t;

  // A flit may not leave through the port it arrived on (no U-turns,
  // no local-to-local loopback).
  function automatic logic NL_route_valid_turn(input int in_port, input int out_port);
    return (in_port != out_port);
  endfunction

endpackage

// File: rtl/nl_rr_arbiter.sv
// N-wide round-robin arbiter.
//   clk, rst_n  : clock, async active-low reset
//   req         : request vector
//   update_en   : advance pointer to winner+1 (only when the grant is used)
//   gnt         : one-hot winner (combinational), any_gnt = |gnt
module nl_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] gnt,
  output logic         any_gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;

  // First pass searches from the pointer upward; if nothing is found the
  // second pass picks the lowest index, which is the wrapped continuation.
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    win     = '0;
    for (int j = 0; j < N; j++) begin
      if (!any_gnt && req[j] && (PW'(j) >= ptr)) begin
        gnt[j]  = 1'b1;
        any_gnt = 1'b1;
        win     = PW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any_gnt && req[j]) begin
        gnt[j]  = 1'b1;
        any_gnt = 1'b1;
        win     = PW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update_en && any_gnt) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/nl_outvc_alloc_ctrl.sv
// Per-output-port VC allocator and credit tracker.
//   clk, rst_n            : clock, async active-low reset
//   req[NP]               : input-port VC requests, held until granted
//   grant[NP], grant_vc[NV]: registered one-hot grant pulse and VC granted
//   flit_sent/flit_vc/flit_tail : flit forwarded on this output
//   credit_in/credit_vc   : credit returned from downstream
//   vc_status[NV]         : VC owned;  vc_blocked[NV]: VC has zero credits
//   err                   : sticky protocol error
//
// Per-VC state:
//   state    | meaning
//   VC_FREE  | unowned; grantable once downstream buffer fully drained
//   VC_ALLOC | owned by a packet until its tail flit is sent
module nl_outvc_alloc_ctrl
  import nl_outvc_alloc_ctrl_pkg::*;
#(
  parameter output_port_t OUTPUT_PORT = PORT_LOCAL,
  parameter int NP        = NL_NP,
  parameter int NV        = NL_NV,
  parameter int BUF_DEPTH = NL_BUF_DEPTH,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NP-1:0] req,
  output logic [NP-1:0] grant,
  output logic [NV-1:0] grant_vc,
  input  logic          flit_sent,
  input  logic [NV-1:0] flit_vc,
  input  logic          flit_tail,
  input  logic          credit_in,
  input  logic [NV-1:0] credit_vc,
  output logic [NV-1:0] vc_status,
  output logic [NV-1:0] vc_blocked,
  output logic          err
);

  logic [CW-1:0] credit [NV];
  vc_state_t     vc_state [NV];

  logic [NP-1:0] turn_mask, eligible, arb_gnt;
  logic          arb_any;
  logic [NV-1:0] free_vc;
  logic          free_any, do_grant;
  logic          flit_ok, credit_ok, err_next;
  logic [NV-1:0] cdec, cinc, c_under, c_over;

  always_comb begin
    turn_mask = '0;
    for (int p = 0; p < NP; p++) turn_mask[p] = NL_route_valid_turn(p, int'(OUTPUT_PORT));
  end

  // The requester granted this cycle still has req high; keep it out.
  assign eligible = req & turn_mask & ~grant;

  // Uses registered state, so a VC freed by a tail this cycle only
  // becomes a candidate next cycle.
  always_comb begin
    free_vc  = '0;
    free_any = 1'b0;
    for (int j = 0; j < NV; j++) begin
      if (!free_any && (vc_state[j] == VC_FREE) && (credit[j] == CW'(BUF_DEPTH))) begin
        free_vc[j] = 1'b1;
        free_any   = 1'b1;
      end
    end
  end

  assign do_grant = arb_any & free_any;

  nl_rr_arbiter #(.N(NP)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (eligible),
    .update_en (do_grant),
    .gnt       (arb_gnt),
    .any_gnt   (arb_any)
  );

  // Malformed VC vectors are ignored for state/credits and only flag err.
  assign flit_ok   = flit_sent & $onehot(flit_vc);
  assign credit_ok = credit_in & $onehot(credit_vc);

  always_comb begin
    cdec       = '0;
    cinc       = '0;
    c_under    = '0;
    c_over     = '0;
    vc_status  = '0;
    vc_blocked = '0;
    for (int j = 0; j < NV; j++) begin
      cdec[j]       = flit_ok & flit_vc[j];
      cinc[j]       = credit_ok & credit_vc[j];
      c_under[j]    = cdec[j] & ~cinc[j] & (credit[j] == '0);
      c_over[j]     = cinc[j] & ~cdec[j] & (credit[j] == CW'(BUF_DEPTH));
      vc_status[j]  = (vc_state[j] == VC_ALLOC);
      vc_blocked[j] = (credit[j] == '0);
    end
  end

  assign err_next = err
                  | (flit_sent & ~$onehot(flit_vc))
                  | (credit_in & ~$onehot(credit_vc))
                  | (flit_ok & |(flit_vc & ~vc_status))
                  | (|c_under)
                  | (|c_over);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      grant_vc <= '0;
      err      <= 1'b0;
      for (int j = 0; j < NV; j++) begin
        vc_state[j] <= VC_FREE;
        credit[j]   <= CW'(BUF_DEPTH);
      end
    end else begin
      grant    <= do_grant ? arb_gnt : '0;
      grant_vc <= do_grant ? free_vc : '0;
      err      <= err_next;
      for (int j = 0; j < NV; j++) begin
        if (do_grant && free_vc[j]) begin
          vc_state[j] <= VC_ALLOC;
        end else if (flit_ok && flit_tail && flit_vc[j]) begin
          vc_state[j] <= VC_FREE;
        end
        // Saturating counter: out-of-range moves hold the value.
        if (cdec[j] && !cinc[j] && !c_under[j]) begin
          credit[j] <= credit[j] - 1'b1;
        end else if (cinc[j] && !cdec[j] && !c_over[j]) begin
          credit[j] <= credit[j] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nl_outvc_alloc_ctrl.sv
module tb_nl_outvc_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] grant;
  logic [3:0] grant_vc;
  logic       flit_sent;
  logic [3:0] flit_vc;
  logic       flit_tail;
  logic       credit_in;
  logic [3:0] credit_vc;
  logic [3:0] vc_status;
  logic [3:0] vc_blocked;
  logic       err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  typedef struct {
    logic [4:0] g;
    logic [3:0] v;
    int         c;
  } exp_t;
  exp_t q[$];

  nl_outvc_alloc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_vc   (grant_vc),
    .flit_sent  (flit_sent),
    .flit_vc    (flit_vc),
    .flit_tail  (flit_tail),
    .credit_in  (credit_in),
    .credit_vc  (credit_vc),
    .vc_status  (vc_status),
    .vc_blocked (vc_blocked),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every grant pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (grant !== 5'b0 || grant_vc !== 4'b0)) begin
      if (q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_grant: got grant=%b vc=%b at cycle %0d, want none", grant, grant_vc, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grant",       32'(grant),    32'(e.g));
        chk("grant_vc",    32'(grant_vc), 32'(e.v));
        chk("grant_cycle", 32'(cyc),      32'(e.c));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; flit_sent = 1'b0; flit_vc = '0; flit_tail = 1'b0;
    credit_in = 1'b0; credit_vc = '0;
    step(2);
    chk("rst_grant",      32'(grant),      'h0);
    chk("rst_grant_vc",   32'(grant_vc),   'h0);
    chk("rst_vc_status",  32'(vc_status),  'h0);
    chk("rst_vc_blocked", 32'(vc_blocked), 'h0);
    chk("rst_err",        32'(err),        'h0);
    rst_n = 1'b1;
    step(1);

    // Round-robin grants: ports 1 then 2, then ptr=3 picks port 3 over 1.
    req = 5'b00110;
    q.push_back('{5'b00010, 4'b0001, cyc + 1});
    q.push_back('{5'b00100, 4'b0010, cyc + 2});
    step(1);
    chk("alloc_vc0", 32'(vc_status), 'b0001);
    req = 5'b00100;
    step(1);
    chk("alloc_vc1", 32'(vc_status), 'b0011);
    req = 5'b01010;
    q.push_back('{5'b01000, 4'b0100, cyc + 1});
    step(1);
    req = 5'b00010;
    q.push_back('{5'b00010, 4'b1000, cyc + 1});
    step(1);
    req = '0;
    chk("alloc_all", 32'(vc_status), 'b1111);
    step(2);

    // Credits on VC0.
    flit_sent = 1'b1; flit_vc = 4'b0001; flit_tail = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("blocked_drain", 32'(vc_blocked), (i == 4) ? 'b0001 : 'b0000);
    end
    flit_sent = 1'b0; credit_in = 1'b1; credit_vc = 4'b0001;
    step(1);
    chk("blocked_credit1", 32'(vc_blocked), 'b0000);
    step(1);
    flit_sent = 1'b1;
    step(1);
    credit_in = 1'b0;
    step(1);
    chk("simul_hold_a", 32'(vc_blocked), 'b0000);
    step(1);
    chk("simul_hold_b", 32'(vc_blocked), 'b0001);
    flit_sent = 1'b0; credit_in = 1'b1; credit_vc = 4'b0001;
    step(4);
    credit_in = 1'b0;
    chk("no_err_credits", 32'(err), 'h0);

    // Tail on VC1 frees it, but regrant waits for full credits.
    req = 5'b10000;
    flit_sent = 1'b1; flit_vc = 4'b0010; flit_tail = 1'b1;
    step(1);
    flit_sent = 1'b0; flit_tail = 1'b0;
    chk("tail_free_vc1", 32'(vc_status), 'b1101);
    step(3);
    chk("vc1_not_regrant", 32'(vc_status), 'b1101);
    credit_in = 1'b1; credit_vc = 4'b0010;
    q.push_back('{5'b10000, 4'b0010, cyc + 2});
    step(1);
    credit_in = 1'b0;
    step(1);
    req = '0;
    chk("vc1_regrant", 32'(vc_status), 'b1111);

    // All VCs owned: no grant until VC2 tail + credit return.
    req = 5'b10000;
    step(3);
    chk("full_no_grant", 32'(vc_status), 'b1111);
    flit_sent = 1'b1; flit_vc = 4'b0100; flit_tail = 1'b1;
    q.push_back('{5'b10000, 4'b0100, cyc + 3});
    step(1);
    flit_sent = 1'b0; flit_tail = 1'b0; credit_in = 1'b1; credit_vc = 4'b0100;
    step(1);
    credit_in = 1'b0;
    step(1);
    req = '0;
    chk("vc2_regrant", 32'(vc_status), 'b1111);
    chk("no_err_alloc", 32'(err), 'h0);
    step(1);

    // Asynchronous reset in the middle of a grant pulse.
    flit_sent = 1'b1; flit_vc = 4'b0001; flit_tail = 1'b1;
    step(1);
    flit_sent = 1'b0; flit_tail = 1'b0; credit_in = 1'b1; credit_vc = 4'b0001;
    step(1);
    credit_in = 1'b0;
    req = 5'b00010;
    @(posedge clk); #2;
    chk("midgrant_pulse", 32'(grant), 'b00010);
    chk("midgrant_vc", 32'(vc_status), 'b1111);
    #1 rst_n = 1'b0;
    #1;
    chk("async_grant",    32'(grant),     'h0);
    chk("async_grant_vc", 32'(grant_vc),  'h0);
    chk("async_status",   32'(vc_status), 'h0);
    req = '0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Credit overflow at BUF_DEPTH: err, counter saturates at 4.
    credit_in = 1'b1; credit_vc = 4'b1000;
    step(1);
    credit_in = 1'b0;
    chk("overflow_err", 32'(err), 'h1);
    req = 5'b00010; q.push_back('{5'b00010, 4'b0001, cyc + 1}); step(1);
    req = 5'b00100; q.push_back('{5'b00100, 4'b0010, cyc + 1}); step(1);
    req = 5'b01000; q.push_back('{5'b01000, 4'b0100, cyc + 1}); step(1);
    req = 5'b10000; q.push_back('{5'b10000, 4'b1000, cyc + 1}); step(1);
    req = '0;
    flit_sent = 1'b1; flit_vc = 4'b1000; flit_tail = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("sat_drain", 32'(vc_blocked), (i == 4) ? 'b1000 : 'b0000);
    end
    flit_sent = 1'b0;
    step(2);
    chk("err_sticky", 32'(err), 'h1);

    // Flit on a FREE VC.
    do_reset();
    chk("err_cleared", 32'(err), 'h0);
    flit_sent = 1'b1; flit_vc = 4'b1000;
    step(1);
    flit_sent = 1'b0;
    chk("free_send_err", 32'(err), 'h1);
    step(3);
    chk("free_send_sticky", 32'(err), 'h1);

    // Non-one-hot flit_vc: err, credits untouched.
    do_reset();
    flit_sent = 1'b1; flit_vc = 4'b0011;
    step(4);
    flit_sent = 1'b0;
    chk("nonhot_err", 32'(err), 'h1);
    chk("nonhot_credits", 32'(vc_blocked), 'b0000);

    // Requests only from the masked port (0 -> output 0) are never granted.
    do_reset();
    req = 5'b00001;
    step(8);
    req = '0;
    chk("illegal_turn_status", 32'(vc_status), 'h0);
    step(2);

    chk("scoreboard_empty", 32'(q.size()), 'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
